serial_pattern_tx: RTL and testbench

Serial frame generator that drives the single-bit input of the team's "101" Mealy sequence detector and similar bit-serial receivers. It accepts a parallel data word through a valid/ready handshake. It then emits one frame on a registered serial output: a fixed preamble, the data MSB-first, an optional parity bit, and a zero gap. It is the stimulus and transmit end of the serial pattern path: test harnesses and upstream logic use it to produce deterministic bit streams at one bit per clock.

---
 rtl/serial_pattern_tx.sv | 175 +++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
//
// Bit-serial frame generator. It accepts a parallel payload word through a
// valid/ready handshake and emits one frame at one bit per clock:
//   preamble (MSB-first) | payload (MSB-first) | [even parity] | zero gap
// It feeds bit-serial receivers such as the "101" sequence detector.
//
// Configuration macro:
//   SERIAL_PATTERN_TX_PARITY_EN - when defined, an even-parity bit (the XOR of
//                                 all payload bits) follows the payload.
//
// Ports:
//   clk         in            rising-edge clock
//   reset       in            asynchronous, active-high reset
//   load_data   in  [DATA_W]  payload word, sampled on the accepting edge
//   load_valid  in            payload request
//   load_ready  out           block can accept a payload this cycle (registered)
//   a_out       out           serial bit stream (registered)
//   busy        out           frame in progress (registered)
//   done        out           one-cycle pulse in the first IDLE cycle after a
//                             completed frame (registered)
// ---------------------------------------------------------------------------
module serial_pattern_tx #(
  parameter int               DATA_W   = 8,
  parameter int               PRE_W    = 3,
  parameter logic [PRE_W-1:0] PREAMBLE = 3'b101,
  parameter int               GAP_LEN  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              a_out,
  output logic              busy,
  output logic              done
);

  // Counter holds the number of bits still to send in the current state
  // after the one on a_out, so it must hold up to the longest field length.
  localparam int MAX_PD  = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_LEN = (MAX_PD > GAP_LEN) ? MAX_PD : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [PRE_W-1:0]  pre_q;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic              par_q;
`endif

  // Every output is a flop. Each transition loads a_out with the first bit
  // of the state being entered, so the serial stream never passes through
  // combinational logic from an input.
  // NOTE: sequential state uses non-blocking assignments only; blocking
  // assignments here would let later statements see updated values and
  // create ordering-dependent races between flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      pre_q      <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
      a_out      <= 1'b0;
      load_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the GAP->IDLE transition raises it.
      done <= 1'b0;

      case (state_q)
        S_IDLE: begin
          a_out <= 1'b0;
          if (load_valid) begin
            state_q    <= S_PRE;
            cnt_q      <= PRE_LAST;
            shift_q    <= load_data;
            // First preamble bit goes out now; the rest wait in pre_q.
            pre_q      <= PREAMBLE << 1;
            a_out      <= PREAMBLE[PRE_W-1];
            busy       <= 1'b1;
            load_ready <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_q      <= ^load_data;
`endif
          end
        end

        S_PRE: begin
          if (cnt_q == '0) begin
            state_q <= S_DATA;
            cnt_q   <= DATA_LAST;
            a_out   <= shift_q[DATA_W-1];
            shift_q <= shift_q << 1;
          end else begin
            cnt_q   <= cnt_q - CNT_ONE;
            a_out   <= pre_q[PRE_W-1];
            pre_q   <= pre_q << 1;
          end
        end

        S_DATA: begin
          if (cnt_q == '0) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            state_q <= S_PAR;
            cnt_q   <= '0;
            a_out   <= par_q;
`else
            state_q <= S_GAP;
            cnt_q   <= GAP_LAST;
            a_out   <= 1'b0;
`endif
          end else begin
            cnt_q   <= cnt_q - CNT_ONE;
            a_out   <= shift_q[DATA_W-1];
            shift_q <= shift_q << 1;
          end
        end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
        S_PAR: begin
          state_q <= S_GAP;
          cnt_q   <= GAP_LAST;
          a_out   <= 1'b0;
        end
`endif

        S_GAP: begin
          a_out <= 1'b0;
          if (cnt_q == '0) begin
            // Entering IDLE takes a full cycle before the next accept, which
            // is what spaces back-to-back frames by exactly one idle bit.
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
            done       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          a_out      <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_tx
//
// Self-checking bench for serial_pattern_tx. Expected frames are built from
// the frame format as a bit queue (preamble, payload MSB-first, optional
// parity, gap zeros). Inputs change and outputs are sampled on the falling
// clock edge.
// ---------------------------------------------------------------------------
module tb_serial_pattern_tx;

  localparam int               DATA_W   = 8;
  localparam int               PRE_W    = 3;
  localparam logic [PRE_W-1:0] PREAMBLE = 3'b101;
  localparam int               GAP_LEN  = 2;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = PRE_W + DATA_W + P + GAP_LEN;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_ready;
  logic              a_out;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  serial_pattern_tx #(
    .DATA_W  (DATA_W),
    .PRE_W   (PRE_W),
    .PREAMBLE(PREAMBLE),
    .GAP_LEN (GAP_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_data (load_data),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .a_out     (a_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference frame: a plain list of the bits that must appear on a_out.
  function automatic void model_frame(input logic [DATA_W-1:0] d);
    logic [PRE_W-1:0] pre;
    bit par;
    pre = PREAMBLE;
    par = 1'b0;
    exp_q.delete();
    for (int i = PRE_W - 1; i >= 0; i--) exp_q.push_back(pre[i]);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      exp_q.push_back(d[i]);
      par = par ^ d[i];
    end
    if (P == 1) exp_q.push_back(par);
    for (int i = 0; i < GAP_LEN; i++) exp_q.push_back(1'b0);
  endfunction

  // Starts at a falling edge with the DUT idle; ends at the falling edge of
  // the done cycle. meddle pulses load_valid and flips load_data mid-payload.
  task automatic run_frame(input logic [DATA_W-1:0] d, input bit keep_valid,
                           input bit meddle);
    load_data  = d;
    load_valid = 1'b1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: load_ready=%b expected 1", load_ready);
    end
    model_frame(d);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) load_valid = 1'b0;
    for (int i = 0; i < F; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (a_out !== exp_q[i]) begin
        errors++;
        $display("FAIL frame_bit[%0d] data=%h: a_out=%b expected %b", i, d,
                 a_out, exp_q[i]);
      end
      checks++;
      if ({busy, load_ready, done} !== 3'b100) begin
        errors++;
        $display("FAIL frame_status[%0d]: busy/ready/done=%b expected 100", i,
                 {busy, load_ready, done});
      end
      if (meddle && i == PRE_W + 2) begin
        load_valid = 1'b1;
        load_data  = ~d;
      end
      if (meddle && i == PRE_W + 3) begin
        load_valid = keep_valid;
        load_data  = d;
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, load_ready, done, a_out} !== 4'b0110) begin
      errors++;
      $display("FAIL frame_done data=%h: busy/ready/done/a_out=%b expected 0110",
               d, {busy, load_ready, done, a_out});
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, load_ready, done, a_out} !== 4'b0100) begin
        errors++;
        $display("FAIL idle[%0d]: busy/ready/done/a_out=%b expected 0100", i,
                 {busy, load_ready, done, a_out});
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_out, load_ready, busy, done} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_async: a_out/ready/busy/done=%b expected 0100",
               {a_out, load_ready, busy, done});
    end
    @(negedge clk);
    reset = 1'b0;
    idle_check(2);
  endtask

  task automatic test_defaults();
    run_frame(8'hA5, 1'b0, 1'b0);
    idle_check(1);
    run_frame(8'h01, 1'b0, 1'b0);
    idle_check(1);
  endtask

  task automatic test_back_to_back();
    run_frame(8'hA5, 1'b1, 1'b0);
    run_frame(8'h01, 1'b1, 1'b0);
    run_frame(DATA_W'($urandom), 1'b1, 1'b0);
    load_valid = 1'b0;
    idle_check(2);
  endtask

  task automatic test_random();
    repeat (8) begin
      run_frame(DATA_W'($urandom), 1'b0, 1'b0);
      idle_check($urandom_range(0, 3));
    end
  endtask

  task automatic test_ignore_while_busy();
    run_frame(DATA_W'($urandom), 1'b0, 1'b1);
    idle_check(4);
  endtask

  task automatic test_abort();
    load_data  = 8'hFF;
    load_valid = 1'b1;
    model_frame(8'hFF);
    @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i <= PRE_W + 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (a_out !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_bit[%0d]: a_out=%b expected %b", i, a_out, exp_q[i]);
      end
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({a_out, load_ready, busy, done} !== 4'b0100) begin
      errors++;
      $display("FAIL abort_reset: a_out/ready/busy/done=%b expected 0100",
               {a_out, load_ready, busy, done});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Long enough to cover where the abandoned frame would have ended.
    idle_check(F + 2);
    run_frame(8'h00, 1'b0, 1'b0);
    idle_check(1);
  endtask

  // Behavioural "101" Mealy detector on a_out: it fires in the cycle whose
  // bit completes 1,0,1. With zero payloads only the preamble can match.
  task automatic test_detector();
    bit h1, h0, a, prev_busy;
    int pos, frames, hits, bad;
    h1 = 1'b0; h0 = 1'b0; prev_busy = 1'b0;
    pos = 0; frames = 0; hits = 0; bad = 0;
    load_data  = '0;
    load_valid = 1'b1;
    for (int c = 0; c < 3 * (F + 1); c++) begin
      @(negedge clk);
      a = a_out;
      if (busy && !prev_busy) begin
        pos = 0;
        frames++;
      end else begin
        pos++;
      end
      if ({h1, h0, a} == 3'b101) begin
        hits++;
        if (!(busy && pos == 2)) bad++;
      end
      h1 = h0;
      h0 = a;
      prev_busy = busy;
    end
    load_valid = 1'b0;
    checks++;
    if (frames !== 3) begin
      errors++;
      $display("FAIL detector_frames: frames=%0d expected 3", frames);
    end
    checks++;
    if (hits !== frames) begin
      errors++;
      $display("FAIL detector_hits: hits=%0d expected %0d", hits, frames);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL detector_position: misplaced=%0d expected 0", bad);
    end
    idle_check(2);
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_back_to_back();
    test_random();
    test_ignore_while_busy();
    test_abort();
    test_detector();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
